// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the calculator op sequencer: function codes, FSM state
// encodings and the instruction decode helper.
package calc_op_sequencer_pkg;

    localparam logic [2:0] FUNCT_NOP  = 3'b000;
    localparam logic [2:0] FUNCT_ADD  = 3'b001;
    localparam logic [2:0] FUNCT_SUB  = 3'b010;
    localparam logic [2:0] FUNCT_ADDP = 3'b011;
    localparam logic [2:0] FUNCT_SUBP = 3'b100;
    localparam logic [2:0] FUNCT_MUL  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic is_mul;
        logic is_sub;
        logic use_acc;
        logic writes_acc;
        logic illegal;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [2:0] funct);
        op_dec_t d;
        d = '{default: 1'b0};
        case (funct)
            FUNCT_NOP:  d.writes_acc = 1'b0;
            FUNCT_ADD:  d.writes_acc = 1'b1;
            FUNCT_SUB:  begin d.writes_acc = 1'b1; d.is_sub = 1'b1; end
            FUNCT_ADDP: begin d.writes_acc = 1'b1; d.use_acc = 1'b1; end
            FUNCT_SUBP: begin d.writes_acc = 1'b1; d.use_acc = 1'b1; d.is_sub = 1'b1; end
            FUNCT_MUL:  d.is_mul = 1'b1;
            default:    d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/calc_op_sequencer_shift_add_mul.sv
// Iterative shift-add multiplier: one partial-product step per step_i cycle.
// Optional CALC_SEQ_EARLY_TERM_EN stops as soon as the remaining multiplier bits are zero.
module shift_add_mul
    import calc_op_sequencer_pkg::*;
#(
    parameter int OPW  = 14,
    parameter int ACCW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    output logic            done_o,
    output logic [ACCW-1:0] product_o
);

    localparam int CNTW = $clog2(OPW + 1);

    logic [ACCW-1:0] m_q, m_d;
    logic [OPW-1:0]  q_q, q_d;
    logic [ACCW-1:0] p_q, p_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            last_s;

    // Next-state for the M/Q/P/cnt datapath: load on start, shift-add on step.
    always_comb begin
        m_d   = m_q;
        q_d   = q_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (start_i) begin
            m_d   = {{(ACCW-OPW){1'b0}}, a_i};
            q_d   = b_i;
            p_d   = {ACCW{1'b0}};
            cnt_d = {CNTW{1'b0}};
        end else if (step_i) begin
            if (q_q[0]) begin
                p_d = p_q + m_q;
            end else begin
                p_d = p_q;
            end
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The step that completes the product; product_o carries the post-step value
    // so the caller can commit it on the same edge.
    always_comb begin
`ifdef CALC_SEQ_EARLY_TERM_EN
        last_s = (cnt_d == CNTW'(OPW)) || (q_d == {OPW{1'b0}});
`else
        last_s = (cnt_d == CNTW'(OPW));
`endif
    end

    assign done_o    = step_i && last_s;
    assign product_o = p_d;

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= {ACCW{1'b0}};
            q_q   <= {OPW{1'b0}};
            p_q   <= {ACCW{1'b0}};
            cnt_q <= {CNTW{1'b0}};
        end else begin
            m_q   <= m_d;
            q_q   <= q_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator op sequencer: accepts one instruction per handshake, owns the accumulator
// and presents results through valid/ready. Build option: CALC_SEQ_EARLY_TERM_EN.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int OPW  = 14,
    parameter int ACCW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct,
    input  logic [OPW-1:0]  imm_a,
    input  logic [OPW-1:0]  imm_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] result,
    output logic            illegal,
    output logic            busy
);

    logic [1:0]      state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            illegal_q, illegal_d;

    op_dec_t         dec_s;
    logic [ACCW-1:0] opa_s;
    logic [ACCW-1:0] opb_s;
    logic [ACCW-1:0] addsub_s;
    logic            mul_start_s;
    logic            mul_step_s;
    logic            mul_done_s;
    logic [ACCW-1:0] mul_product_s;

    // Subtraction is a + ~b + 1 through the same adder.
    function automatic logic [ACCW-1:0] add_sub(input logic [ACCW-1:0] a,
                                                 input logic [ACCW-1:0] b,
                                                 input logic            sub);
        logic [ACCW-1:0] b_eff;
        if (sub) begin
            b_eff = ~b;
        end else begin
            b_eff = b;
        end
        return a + b_eff + {{(ACCW-1){1'b0}}, sub};
    endfunction

    // Decode and add/sub operand selection; ADDP/SUBP take the accumulator as B.
    always_comb begin
        dec_s = decode_op(funct);
        opa_s = {{(ACCW-OPW){1'b0}}, imm_a};
        if (dec_s.use_acc) begin
            opb_s = acc_q;
        end else begin
            opb_s = {{(ACCW-OPW){1'b0}}, imm_b};
        end
        addsub_s = add_sub(opa_s, opb_s, dec_s.is_sub);
    end

    // Sequencer FSM with accumulator and illegal-flag update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        illegal_d   = illegal_q;
        mul_start_s = 1'b0;
        mul_step_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    illegal_d = dec_s.illegal;
                    if (dec_s.is_mul) begin
                        mul_start_s = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        if (dec_s.writes_acc) begin
                            acc_d = addsub_s;
                        end else begin
                            acc_d = acc_q;
                        end
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                if (mul_done_s) begin
                    acc_d   = mul_product_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    shift_add_mul #(
        .OPW  (OPW),
        .ACCW (ACCW)
    ) u_mul (
        .clk       (clk),
        .rst_n     (reset),
        .start_i   (mul_start_s),
        .step_i    (mul_step_s),
        .a_i       (imm_a),
        .b_i       (imm_b),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // State, accumulator and illegal flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= {ACCW{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL);
    assign result    = acc_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed, table-driven bench for calc_op_sequencer with hand-written corner sequences.
module tb_calc_op_sequencer;

`ifdef CALC_SEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct;
    logic [13:0] imm_a;
    logic [13:0] imm_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;

    calc_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .imm_a     (imm_a),
        .imm_b     (imm_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  funct;
        logic [13:0] a;
        logic [13:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int edges;
        int busy_cnt;
        chk($sformatf("v%0d in_ready", idx), {31'd0, in_ready}, 32'd1);
        funct     = v.funct;
        imm_a     = v.a;
        imm_b     = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        funct    = 3'b111;
        imm_a    = 14'h2AAA;
        imm_b    = 14'h1555;
        edges    = 1;
        busy_cnt = 0;
        while (!out_valid && edges < 64) begin
            if (busy) busy_cnt++;
            tick();
            edges++;
        end
        chk($sformatf("v%0d latency", idx), edges, v.lat);
        chk($sformatf("v%0d result", idx), result, v.res);
        chk($sformatf("v%0d illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
        chk($sformatf("v%0d busy_cycles", idx), busy_cnt, (v.funct == 3'b101) ? v.lat - 1 : 0);
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct     = 3'b000;
        imm_a     = 14'd0;
        imm_b     = 14'd0;

        vecs[0]  = '{3'b001, 14'd100,   14'd23,    32'd123,        1'b0, 1};
        vecs[1]  = '{3'b100, 14'd0,     14'd0,     32'hFFFFFF85,   1'b0, 1};
        vecs[2]  = '{3'b011, 14'd5,     14'd0,     32'hFFFFFF8A,   1'b0, 1};
        vecs[3]  = '{3'b010, 14'd10,    14'd20,    32'hFFFFFFF6,   1'b0, 1};
        vecs[4]  = '{3'b000, 14'd7,     14'd7,     32'hFFFFFFF6,   1'b0, 1};
        vecs[5]  = '{3'b001, 14'd1,     14'd8,     32'd9,          1'b0, 1};
        vecs[6]  = '{3'b110, 14'd50,    14'd60,    32'd9,          1'b1, 1};
        vecs[7]  = '{3'b111, 14'd1,     14'd1,     32'd9,          1'b1, 1};
        vecs[8]  = '{3'b001, 14'h3FFF,  14'h3FFF,  32'h00007FFE,   1'b0, 1};
        vecs[9]  = '{3'b101, 14'h3FFF,  14'h3FFF,  32'h0FFF8001,   1'b0, EARLY ? 15 : 15};
        vecs[10] = '{3'b101, 14'd7,     14'd1,     32'd7,          1'b0, EARLY ? 2 : 15};
        vecs[11] = '{3'b101, 14'd123,   14'd0,     32'd0,          1'b0, EARLY ? 2 : 15};
        vecs[12] = '{3'b100, 14'd1,     14'd0,     32'd1,          1'b0, 1};
        vecs[13] = '{3'b101, 14'd3,     14'd5,     32'd15,         1'b0, EARLY ? 4 : 15};

        // Reset state
        #12;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst illegal", {31'd0, illegal}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a MUL discards it immediately
        funct    = 3'b101;
        imm_a    = 14'd3;
        imm_b    = 14'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst result", result, 32'd0);
        chk("mid_rst busy", {31'd0, busy}, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst result", result, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(i, vecs[i]);
        end

        // Backpressure: result held, no accept while DONE
        funct     = 3'b001;
        imm_a     = 14'd1;
        imm_b     = 14'd1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        funct = 3'b001;
        imm_a = 14'd5;
        imm_b = 14'd5;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d result", k), result, 32'd2);
            chk($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release result", result, 32'd2);
        tick();
        in_valid = 1'b0;
        chk("bp second out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp second result", result, 32'd10);
        tick();
        chk("bp final in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
